// File: rtl/mem_access_if.sv
// Memory-stage bus: instruction/operand inputs from the pipeline and the
// read data, fault flag and status returned by the memory stage.
interface mem_access_if;
  logic [3:0]  icode;
  logic [63:0] valA;
  logic [63:0] valE;
  logic [63:0] valP;
  logic        instr_valid;
  logic        imem_error;
  logic [63:0] valM;
  logic        dmem_error;
  logic [2:0]  stat;

  modport master (
    output icode, valA, valE, valP, instr_valid, imem_error,
    input  valM, dmem_error, stat
  );

  modport slave (
    input  icode, valA, valE, valP, instr_valid, imem_error,
    output valM, dmem_error, stat
  );
endinterface

// File: rtl/mem_access.sv
// Y86-64 memory stage: 1 KiB byte-addressed data memory with 8-byte
// little-endian word access, address fault detection and a sticky status register.
module mem_access (
  input  logic         clk,
  input  logic         rst,
  mem_access_if.slave  bus
);
  localparam int unsigned MEM_BYTES = 1024;
  localparam logic [63:0] MAX_ADDR  = 64'd1016;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  logic [7:0]  mem_q [MEM_BYTES];
  logic [63:0] addr;
  logic [63:0] wr_data;
  logic        rd_en;
  logic        wr_en;
  logic        addr_bad;
  logic [9:0]  addr_idx;
  logic [63:0] rd_word;
  logic        wr_commit;
  stat_e       stat_q;
  stat_e       stat_d;

  always_comb begin
    addr    = bus.valE;
    wr_data = bus.valA;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    case (bus.icode)
      I_RMMOVQ: wr_en = 1'b1;
      I_MRMOVQ: rd_en = 1'b1;
      I_CALL: begin
        wr_en   = 1'b1;
        wr_data = bus.valP;
      end
      I_RET: begin
        rd_en = 1'b1;
        addr  = bus.valA;
      end
      I_PUSHQ: wr_en = 1'b1;
      I_POPQ: begin
        rd_en = 1'b1;
        addr  = bus.valA;
      end
      default: ;
    endcase
  end

  // Full 64-bit compare so the last word starting at 1016 is the highest legal one.
  assign addr_bad        = addr[63] || (addr > MAX_ADDR);
  assign bus.dmem_error  = (rd_en || wr_en) && addr_bad;
  assign addr_idx        = addr[9:0];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rd_lane
      assign rd_word[8*gi +: 8] = mem_q[addr_idx + 10'(gi)];
    end
  endgenerate

  assign bus.valM = (rd_en && !addr_bad) ? rd_word : 64'd0;

  // A write held under reset, after a fault, or to a bad address never lands.
  assign wr_commit = wr_en && !addr_bad && (stat_q == STAT_AOK) && !rst;

  always_ff @(posedge clk) begin
    if (wr_commit) begin
      for (int k = 0; k < 8; k++) begin
        mem_q[addr_idx + 10'(k)] <= wr_data[8*k +: 8];
      end
    end
  end

  always_comb begin
    stat_d = stat_q;
    if (stat_q == STAT_AOK) begin
      if (bus.imem_error)        stat_d = STAT_ADR;
      else if (!bus.instr_valid) stat_d = STAT_INS;
      else if (bus.dmem_error)   stat_d = STAT_ADR;
      else if (bus.icode == I_HALT) stat_d = STAT_HLT;
      else                       stat_d = STAT_AOK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stat_q <= STAT_AOK;
    else     stat_q <= stat_d;
  end

  assign bus.stat = stat_q;
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a table of one-cycle vectors plus hand-written
// reset, priority and fault sequences.
module tb_mem_access;
  logic clk;
  logic rst;
  mem_access_if bus ();

  mem_access dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode;
    logic [63:0] valA;
    logic [63:0] valE;
    logic [63:0] valP;
    logic        chk_m;
    logic [63:0] exp_m;
    logic        exp_err;
    logic [2:0]  exp_stat;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;
  vec_t tbl[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%016h", name, act);
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                       input logic [63:0] p, input logic iv, input logic ie);
    bus.icode = ic; bus.valA = a; bus.valE = e; bus.valP = p;
    bus.instr_valid = iv; bus.imem_error = ie;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(4'h1, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check("reset_stat", {61'd0, bus.stat}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One cycle: drive at negedge, check comb outputs, check stat after the edge.
  task automatic run_vec(input string tag, input vec_t v);
    @(negedge clk);
    drive(v.icode, v.valA, v.valE, v.valP, 1'b1, 1'b0);
    #1;
    if (v.chk_m) check({tag, "_valM"}, bus.valM, v.exp_m);
    check({tag, "_derr"}, {63'd0, bus.dmem_error}, {63'd0, v.exp_err});
    @(posedge clk);
    #1;
    check({tag, "_stat"}, {61'd0, bus.stat}, {61'd0, v.exp_stat});
  endtask

  initial begin
    rst = 1'b1;
    drive(4'h1, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);
    #1;
    check("por_stat", {61'd0, bus.stat}, 64'd1);
    @(negedge clk);
    rst = 1'b0;

    //          icode  valA                    valE                    valP    chk   exp_m                   err   stat
    tbl[0]  = '{4'h4, 64'h1122334455667788,   64'd16,                 64'd0,  1'b0, 64'd0,                  1'b0, 3'd1};
    tbl[1]  = '{4'h5, 64'd0,                  64'd16,                 64'd0,  1'b1, 64'h1122334455667788,   1'b0, 3'd1};
    tbl[2]  = '{4'h8, 64'd7,                  64'd1000,               64'h40, 1'b0, 64'd0,                  1'b0, 3'd1};
    tbl[3]  = '{4'h9, 64'd1000,               64'd5,                  64'd0,  1'b1, 64'h40,                 1'b0, 3'd1};
    tbl[4]  = '{4'hA, 64'hA5A5_0000_5A5A_1234, 64'd0,                 64'd9,  1'b0, 64'd0,                  1'b0, 3'd1};
    tbl[5]  = '{4'h4, 64'hCAFEBABEDEADBEEF,   64'd1016,               64'd0,  1'b0, 64'd0,                  1'b0, 3'd1};
    tbl[6]  = '{4'hB, 64'd1016,               64'd3,                  64'd0,  1'b1, 64'hCAFEBABEDEADBEEF,   1'b0, 3'd1};
    tbl[7]  = '{4'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5000,              64'd0,  1'b1, 64'd0,                  1'b0, 3'd1};
    tbl[8]  = '{4'h6, 64'd4000,               64'h8000_0000_0000_0000, 64'd0, 1'b0, 64'd0,                  1'b0, 3'd1};
    tbl[9]  = '{4'h5, 64'd0,                  64'd0,                  64'd0,  1'b1, 64'hA5A5_0000_5A5A_1234, 1'b0, 3'd1};
    tbl[10] = '{4'hA, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1017,              64'd0,  1'b0, 64'd0,                  1'b1, 3'd3};
    tbl[11] = '{4'h5, 64'd0,                  64'd1016,               64'd0,  1'b1, 64'hCAFEBABEDEADBEEF,   1'b0, 3'd3};
    tbl[12] = '{4'h4, 64'h0123456789ABCDEF,   64'd0,                  64'd0,  1'b0, 64'd0,                  1'b0, 3'd3};
    tbl[13] = '{4'h5, 64'd0,                  64'd0,                  64'd0,  1'b1, 64'hA5A5_0000_5A5A_1234, 1'b0, 3'd3};
    tbl[14] = '{4'h0, 64'd0,                  64'd0,                  64'd0,  1'b0, 64'd0,                  1'b0, 3'd3};

    for (int i = 0; i < 15; i++) begin
      run_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // Byte placement of the first store: byte 16 holds the low byte.
    do_reset();
    @(negedge clk);
    drive(4'h5, 64'd0, 64'd16, 64'd0, 1'b1, 1'b0);
    #1;
    check("byte16", {56'd0, bus.valM[7:0]}, 64'h88);
    drive(4'h5, 64'd0, 64'd17, 64'd0, 1'b1, 1'b0);
    #1;
    check("byte17", {56'd0, bus.valM[7:0]}, 64'h77);

    // Halt, then imem_error outranks instr_valid.
    do_reset();
    @(negedge clk);
    drive(4'h0, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("halt_stat", {61'd0, bus.stat}, 64'd2);
    do_reset();
    @(negedge clk);
    drive(4'h0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("imem_prio", {61'd0, bus.stat}, 64'd3);
    do_reset();
    @(negedge clk);
    drive(4'h5, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("ins_prio", {61'd0, bus.stat}, 64'd4);

    // popq from -8 faults; async reset clears status mid-cycle.
    do_reset();
    @(negedge clk);
    drive(4'hB, 64'hFFFF_FFFF_FFFF_FFF8, 64'd16, 64'd0, 1'b1, 1'b0);
    #1;
    check("pop_neg_derr", {63'd0, bus.dmem_error}, 64'd1);
    check("pop_neg_valM", bus.valM, 64'd0);
    @(posedge clk); #1;
    check("pop_neg_stat", {61'd0, bus.stat}, 64'd3);
    @(negedge clk);
    drive(4'h1, 64'd0, 64'd0, 64'd0, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst", {61'd0, bus.stat}, 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Store held under reset must not land.
    @(negedge clk);
    drive(4'h4, 64'h1111, 64'd32, 64'd0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    drive(4'h4, 64'h2222, 64'd32, 64'd0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(4'h5, 64'd0, 64'd32, 64'd0, 1'b1, 1'b0);
    #1;
    check("rst_wr_supp", bus.valM, 64'h1111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
